// File: rtl/instrumented_adder_meter_if.sv
// Bundles the configuration, ring-oscillator and result signals of the
// instrumented adder meter.
//   master : drives active, start, cfg_*, ring_in; observes the results
//   slave  : the meter itself; consumes the controls and drives ring_en,
//            busy, done, sum_out, carry_out, count_out, overflow
interface instrumented_adder_meter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 32,
  parameter int WIN_W   = 16,
  parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic               active;
  logic               start;
  logic [WIDTH-1:0]   cfg_a;
  logic [WIDTH-1:0]   cfg_b;
  logic [SEL_W-1:0]   cfg_sel;
  logic [WIN_W-1:0]   cfg_window;
  logic [NUM_CH-1:0]  ring_in;
  logic [NUM_CH-1:0]  ring_en;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   sum_out;
  logic               carry_out;
  logic [COUNT_W-1:0] count_out;
  logic               overflow;

  modport master (
    output active, start, cfg_a, cfg_b, cfg_sel, cfg_window, ring_in,
    input  ring_en, busy, done, sum_out, carry_out, count_out, overflow
  );

  modport slave (
    input  active, start, cfg_a, cfg_b, cfg_sel, cfg_window, ring_in,
    output ring_en, busy, done, sum_out, carry_out, count_out, overflow
  );
endinterface

// File: rtl/instrumented_adder_meter.sv
// Measurement controller for a bank of ring-oscillator-instrumented adders.
// On start it latches operands, channel and window, registers the adder sum,
// enables the selected ring, lets the synchroniser settle, then counts rising
// ring edges for `window` clocks. The edge count measures the adder's delay.
// Ports:
//   wb_clk_i  system clock
//   wb_rst_i  synchronous reset, active high
//   bus       instrumented_adder_meter_if.slave (controls in, results out)
module instrumented_adder_meter #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 32,
  parameter int WIN_W   = 16,
  parameter int SETTLE  = 4
) (
  input logic                        wb_clk_i,
  input logic                        wb_rst_i,
  instrumented_adder_meter_if.slave  bus
);
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W   = $clog2(SETTLE + 1);
  localparam int TIMER_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [WIN_W-1:0]   win_q;
  logic [TIMER_W-1:0] timer_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               sync1_q, sync2_q, dly_q;
  logic               ring_bit;
  logic               edge_det;
  logic [NUM_CH-1:0]  sel_onehot;
  logic [NUM_CH-1:0]  ring_en_q;
  logic               busy_q, done_q;
  logic [WIDTH:0]     sum_q;
  logic [COUNT_W-1:0] count_q;
  logic               overflow_q;

  // Channel decode; an out-of-range select matches nothing, so no ring is
  // enabled and the sampled tap stays 0.
  always_comb begin
    ring_bit   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ring_bit      = bus.ring_in[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign edge_det = sync2_q & ~dly_q;

  // Working counter next value: saturates, and a saturated hit sets overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_RUN && edge_det) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      win_q      <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      ring_en_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Ring tap: two-flop synchroniser followed by the edge delay flop
      sync1_q <= ring_bit;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;

      if (!bus.active) begin
        state_q   <= S_IDLE;
        ring_en_q <= '0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            done_q <= 1'b0;
            if (bus.start) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
              sel_q   <= bus.cfg_sel;
              win_q   <= bus.cfg_window;
              sum_q   <= {1'b0, bus.cfg_a} + {1'b0, bus.cfg_b};
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end
          end
          S_LOAD: begin
            if (win_q == '0) begin
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              count_q    <= cnt_d;
              overflow_q <= ovf_d;
            end else begin
              state_q   <= S_SETTLE;
              ring_en_q <= sel_onehot;
              timer_q   <= TIMER_W'(SETTLE - 1);
            end
          end
          S_SETTLE: begin
            if (timer_q == '0) begin
              state_q <= S_RUN;
              timer_q <= TIMER_W'(win_q) - TIMER_W'(1);
            end else begin
              timer_q <= timer_q - TIMER_W'(1);
            end
          end
          S_RUN: begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (timer_q == '0) begin
              // Results are published together with the done pulse,
              // including an edge seen on this final window clock.
              state_q    <= S_DONE;
              ring_en_q  <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              count_q    <= cnt_d;
              overflow_q <= ovf_d;
            end else begin
              timer_q <= timer_q - TIMER_W'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q   <= S_IDLE;
            ring_en_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ring_en   = ring_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum_out   = sum_q[WIDTH-1:0];
  assign bus.carry_out = sum_q[WIDTH];
  assign bus.count_out = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_instrumented_adder_meter.sv
module tb_instrumented_adder_meter;
  localparam int W  = 32;
  localparam int NC = 4;
  localparam int WW = 16;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instrumented_adder_meter_if #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(32), .WIN_W(WW)) ifa ();
  instrumented_adder_meter_if #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(4),  .WIN_W(WW)) ifb ();

  instrumented_adder_meter #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(32), .WIN_W(WW), .SETTLE(S)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa.slave));
  instrumented_adder_meter #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(4), .WIN_W(WW), .SETTLE(S)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb.slave));

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic [31:0] cnt_a;
    logic        ovf_a;
    logic [3:0]  cnt_b;
    logic        ovf_b;
    logic [3:0]  ring_en;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ring_mode = 0;
  logic ph = 1'b0;
  logic [NC-1:0] ring_v;
  logic [31:0] last_cnt_a;

  // Ring stimulus: mode 1 all taps toggle together every clock, mode 2 tap 2
  // toggles in antiphase with the others, otherwise all taps held low.
  always @(posedge clk) begin
    #2;
    ph = ~ph;
    case (ring_mode)
      1:       ring_v = {NC{ph}};
      2:       ring_v = ph ? 4'b0100 : 4'b1011;
      default: ring_v = '0;
    endcase
    ifa.ring_in = ring_v;
    ifb.ring_in = ring_v;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                         input logic [15:0] win);
    ifa.cfg_a = a;   ifb.cfg_a = a;
    ifa.cfg_b = b;   ifb.cfg_b = b;
    ifa.cfg_sel = sel;   ifb.cfg_sel = sel;
    ifa.cfg_window = win; ifb.cfg_window = win;
  endtask

  task automatic drive_start(input bit v);
    ifa.start = v;
    ifb.start = v;
  endtask

  task automatic drive_active(input bit v);
    ifa.active = v;
    ifb.active = v;
  endtask

  task automatic meas(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                      input logic [15:0] win, input int mode, input bit poke);
    exp_t e;
    exp_t g;
    int edges;
    logic [32:0] s;
    int n;
    logic [3:0] en_or;
    ring_mode = mode;
    set_cfg(a, b, sel, win);
    s = {1'b0, a} + {1'b0, b};
    edges = (mode != 0 && win != 0) ? int'(win) / 2 : 0;
    e.sum = s[31:0];
    e.carry = s[32];
    e.cnt_a = 32'(edges);
    e.ovf_a = 1'b0;
    e.cnt_b = (edges > 15) ? 4'd15 : 4'(edges);
    e.ovf_b = (edges > 15);
    e.ring_en = (win == 0) ? 4'b0000 : (4'b0001 << sel);
    e.lat = (win == 0) ? 2 : 2 + S + int'(win);
    sb.push_back(e);

    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    n = 1;
    en_or = '0;
    check("busy_in_load", 64'(ifa.busy), 64'(1'b1));
    // Config changes after the start edge must not disturb this run.
    set_cfg(~a, b ^ 32'h5555, sel + 2'd1, win + 16'd3);
    while (!ifa.done && n < e.lat + 20) begin
      en_or |= ifa.ring_en;
      drive_start(poke && n == 10);
      tick();
      n++;
    end
    drive_start(1'b0);

    g = sb.pop_front();
    check("done_latency", 64'(n), 64'(g.lat));
    check("ring_en_seen", 64'(en_or), 64'(g.ring_en));
    check("sum_out", 64'(ifa.sum_out), 64'(g.sum));
    check("carry_out", 64'(ifa.carry_out), 64'(g.carry));
    check("count_a", 64'(ifa.count_out), 64'(g.cnt_a));
    check("ovf_a", 64'(ifa.overflow), 64'(g.ovf_a));
    check("count_b", 64'(ifb.count_out), 64'(g.cnt_b));
    check("ovf_b", 64'(ifb.overflow), 64'(g.ovf_b));
    check("busy_at_done", 64'(ifa.busy), 64'(1'b0));
    last_cnt_a = g.cnt_a;
    tick();
    check("done_one_cycle", 64'(ifa.done), 64'(1'b0));
    tick();
    check("idle_after_done", 64'(ifa.busy), 64'(1'b0));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    drive_active(1'b1);
    drive_start(1'b0);
    set_cfg('0, '0, '0, '0);
    repeat (3) tick();

    // Reset state
    check("rst_ring_en", 64'(ifa.ring_en), 64'(0));
    check("rst_busy", 64'(ifa.busy), 64'(0));
    check("rst_done", 64'(ifa.done), 64'(0));
    check("rst_sum", 64'(ifa.sum_out), 64'(0));
    check("rst_carry", 64'(ifa.carry_out), 64'(0));
    check("rst_count", 64'(ifa.count_out), 64'(0));
    check("rst_ovf", 64'(ifa.overflow), 64'(0));
    check("rst_count_b", 64'(ifb.count_out), 64'(0));
    rst = 1'b0;
    tick();

    // Basic run with a second start poked during RUN; narrow counter saturates
    meas(32'd5, 32'd7, 2'd0, 16'd64, 1, 1'b1);
    // Carry out, rings quiet
    meas(32'hFFFF_FFFF, 32'd1, 2'd1, 16'd32, 0, 1'b0);
    // Zero window: immediate done, no ring enable
    meas(32'd100, 32'd200, 2'd3, 16'd0, 1, 1'b0);
    // Channel 2 selected while neighbours toggle in antiphase
    meas(32'h1234_5678, 32'h0F0F_0F0F, 2'd2, 16'd40, 2, 1'b0);
    // Highest channel, count below the narrow counter's limit
    meas(32'h8000_0000, 32'h8000_0001, 2'd3, 16'd20, 1, 1'b0);

    // Drop active in the middle of RUN
    ring_mode = 1;
    set_cfg(32'd9, 32'd10, 2'd0, 16'd64);
    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    repeat (11) tick();
    check("busy_mid_run", 64'(ifa.busy), 64'(1'b1));
    check("ring_en_mid_run", 64'(ifa.ring_en), 64'(4'b0001));
    drive_active(1'b0);
    tick();
    check("busy_after_drop", 64'(ifa.busy), 64'(0));
    check("ring_en_after_drop", 64'(ifa.ring_en), 64'(0));
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (ifa.done) seen++;
      tick();
    end
    check("no_done_after_drop", 64'(seen), 64'(0));
    check("count_kept", 64'(ifa.count_out), 64'(last_cnt_a));
    check("sum_after_drop", 64'(ifa.sum_out), 64'(32'd19));
    drive_active(1'b1);
    tick();

    // Recovery run after the abort
    meas(32'd1, 32'd2, 2'd1, 16'd10, 1, 1'b0);

    // Reset in the middle of RUN clears every output
    ring_mode = 1;
    set_cfg(32'd3, 32'd4, 2'd0, 16'd64);
    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(ifa.busy), 64'(0));
    check("rst_mid_ring_en", 64'(ifa.ring_en), 64'(0));
    check("rst_mid_sum", 64'(ifa.sum_out), 64'(0));
    check("rst_mid_count", 64'(ifa.count_out), 64'(0));
    check("rst_mid_count_b", 64'(ifb.count_out), 64'(0));
    check("rst_mid_ovf_b", 64'(ifb.overflow), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
